// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg
//   Shared types and constants for the round-robin UART transmitter arbiter.
//   - arb_state_t : arbiter FSM states (TAG_* states exist only when
//                   UART_ARB_TAG_EN is defined)
//   - TAG_HI      : upper nibble of the tag byte (UART_ARB_TAG_EN only)
//   - TMR_W       : width of the start-of-frame timeout counter
//   - IDX_W       : width of a requester index (NUM_REQ <= 16)
//   - wrap_inc()  : index + 1 modulo n
package uart_arb_pkg;

   localparam int unsigned TMR_W = 16;
   localparam int unsigned IDX_W = 4;

`ifdef UART_ARB_TAG_EN
   localparam logic [3:0] TAG_HI = 4'hA;

   typedef enum logic [2:0] {
      IDLE,
      LAUNCH,
      WAIT_START,
      WAIT_DONE,
      TAG_LAUNCH,
      TAG_WAIT_START,
      TAG_WAIT_DONE
   } arb_state_t;
`else
   typedef enum logic [1:0] {
      IDLE,
      LAUNCH,
      WAIT_START,
      WAIT_DONE
   } arb_state_t;
`endif

   function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx,
                                                 input int unsigned     n);
      if (32'(idx) + 32'd1 >= n) return '0;
      return idx + 1'b1;
   endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// rr_priority_pick
//   Combinational round-robin pick: the first asserted request found when
//   searching upward from index ptr, wrapping modulo N.
//   Parameters: N (request count), PTR_W (width of ptr).
//   Ports:
//     req   in  N      request vector
//     ptr   in  PTR_W  index where the search starts
//     win   out N      one-hot winner (all zero when nothing is requested)
//     valid out 1      at least one request is asserted
module rr_priority_pick #(
   parameter int unsigned N     = 4,
   parameter int unsigned PTR_W = 2
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N-1:0]     win,
   output logic             valid
);

   // Two passes replace the modulo walk: indices at or above ptr first,
   // then the wrapped-around indices below ptr.
   always_comb begin
      win   = '0;
      valid = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         if (!valid && req[i] && (i >= 32'(ptr))) begin
            win[i] = 1'b1;
            valid  = 1'b1;
         end
      end
      for (int unsigned i = 0; i < N; i++) begin
         if (!valid && req[i] && (i < 32'(ptr))) begin
            win[i] = 1'b1;
            valid  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one byte-wide UART transmitter between NUM_REQ requesters with
//   round-robin arbitration. The winner's byte is latched, the transmitter is
//   started with a one-cycle tx_en, and its busy level is followed through
//   start and end of frame before done is returned to the winner.
//   Optional build macro UART_ARB_TAG_EN: each grant sends a tag byte
//   {4'hA, winner[3:0]} ahead of the data byte.
//   Parameters: NUM_REQ (2..16), DATA_W (8), START_TIMEOUT (>= 2).
//   Ports:
//     sys_clk     in  1          clock, rising edge
//     reset       in  1          asynchronous, active-low reset
//     req         in  NUM_REQ    request levels, held with data until gnt
//     req_data    in  NUM_REQ*8  packed bytes, requester i at [8i+7:8i]
//     gnt         out NUM_REQ    one-hot grant pulse, byte latched
//     done        out NUM_REQ    one-hot completion pulse
//     tx_data     out 8          byte presented to the transmitter
//     tx_en       out 1          transmitter start pulse
//     tx_busy     in  1          transmitter busy level
//     arb_busy    out 1          arbiter is not idle
//     err_timeout out 1          sticky: tx_busy never rose after a launch
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ       = 4,
   parameter int unsigned DATA_W        = 8,
   parameter int unsigned START_TIMEOUT = 16
) (
   input  logic                      sys_clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        gnt,
   output logic [NUM_REQ-1:0]        done,
   output logic [DATA_W-1:0]         tx_data,
   output logic                      tx_en,
   input  logic                      tx_busy,
   output logic                      arb_busy,
   output logic                      err_timeout
);

   arb_state_t          state, state_nxt;
   logic [IDX_W-1:0]    ptr, ptr_nxt;
   logic [NUM_REQ-1:0]  wsel, wsel_nxt;
   logic [TMR_W-1:0]    timer, timer_nxt;
   logic [NUM_REQ-1:0]  gnt_nxt, done_nxt;
   logic [DATA_W-1:0]   tx_data_nxt;
   logic                tx_en_nxt, arb_busy_nxt, err_nxt;
`ifdef UART_ARB_TAG_EN
   logic [DATA_W-1:0]   data_q, data_q_nxt;
`endif

   logic [NUM_REQ-1:0]  pick_win;
   logic                pick_valid;
   logic [IDX_W-1:0]    pick_idx;
   logic [DATA_W-1:0]   pick_byte;

   rr_priority_pick #(
      .N     (NUM_REQ),
      .PTR_W (IDX_W)
   ) u_pick (
      .req   (req),
      .ptr   (ptr),
      .win   (pick_win),
      .valid (pick_valid)
   );

   always_comb begin
      pick_idx  = '0;
      pick_byte = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (pick_win[i]) begin
            pick_idx  = IDX_W'(i);
            pick_byte = req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   // Every output is computed one cycle ahead and registered, so the actions
   // listed for a state appear on the outputs in the cycle after it.
   always_comb begin
      state_nxt   = state;
      ptr_nxt     = ptr;
      wsel_nxt    = wsel;
      timer_nxt   = timer;
      gnt_nxt     = '0;
      done_nxt    = '0;
      tx_en_nxt   = 1'b0;
      tx_data_nxt = tx_data;
      err_nxt     = err_timeout;
`ifdef UART_ARB_TAG_EN
      data_q_nxt  = data_q;
`endif
      case (state)
         IDLE: begin
            // Foreign traffic on the transmitter blocks arbitration.
            if (pick_valid && !tx_busy) begin
               gnt_nxt  = pick_win;
               wsel_nxt = pick_win;
               ptr_nxt  = wrap_inc(pick_idx, NUM_REQ);
`ifdef UART_ARB_TAG_EN
               tx_data_nxt = {TAG_HI, pick_idx};
               data_q_nxt  = pick_byte;
               state_nxt   = TAG_LAUNCH;
`else
               tx_data_nxt = pick_byte;
               state_nxt   = LAUNCH;
`endif
            end
         end
         LAUNCH: begin
            tx_en_nxt = 1'b1;
            timer_nxt = '0;
            state_nxt = WAIT_START;
         end
         WAIT_START: begin
            if (tx_busy) begin
               state_nxt = WAIT_DONE;
            end else if (timer == TMR_W'(START_TIMEOUT - 1)) begin
               err_nxt   = 1'b1;
               state_nxt = IDLE;
            end else begin
               timer_nxt = timer + 1'b1;
            end
         end
         WAIT_DONE: begin
            if (!tx_busy) begin
               done_nxt  = wsel;
               state_nxt = IDLE;
            end
         end
`ifdef UART_ARB_TAG_EN
         TAG_LAUNCH: begin
            tx_en_nxt = 1'b1;
            timer_nxt = '0;
            state_nxt = TAG_WAIT_START;
         end
         TAG_WAIT_START: begin
            if (tx_busy) begin
               state_nxt = TAG_WAIT_DONE;
            end else if (timer == TMR_W'(START_TIMEOUT - 1)) begin
               err_nxt   = 1'b1;
               state_nxt = IDLE;
            end else begin
               timer_nxt = timer + 1'b1;
            end
         end
         TAG_WAIT_DONE: begin
            if (!tx_busy) begin
               tx_data_nxt = data_q;
               state_nxt   = LAUNCH;
            end
         end
`endif
         default: state_nxt = IDLE;
      endcase
      arb_busy_nxt = (state_nxt != IDLE);
   end

   always_ff @(posedge sys_clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         ptr         <= '0;
         wsel        <= '0;
         timer       <= '0;
         gnt         <= '0;
         done        <= '0;
         tx_en       <= 1'b0;
         tx_data     <= '0;
         arb_busy    <= 1'b0;
         err_timeout <= 1'b0;
`ifdef UART_ARB_TAG_EN
         data_q      <= '0;
`endif
      end else begin
         state       <= state_nxt;
         ptr         <= ptr_nxt;
         wsel        <= wsel_nxt;
         timer       <= timer_nxt;
         gnt         <= gnt_nxt;
         done        <= done_nxt;
         tx_en       <= tx_en_nxt;
         tx_data     <= tx_data_nxt;
         arb_busy    <= arb_busy_nxt;
         err_timeout <= err_nxt;
`ifdef UART_ARB_TAG_EN
         data_q      <= data_q_nxt;
`endif
      end
   end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one byte-wide UART transmitter between NUM_REQ independent requesters using round-robin arbitration. Latches the winning requester's byte and pulses the transmitter's enable. Tracks the transmitter's busy level through start-of-frame and end-of-frame, then reports completion to that requester. Sits between the application clients and the UART transmitter, all on sys_clk.

Parameters:
NUM_REQ, 4, number of requesters; legal range 2..16.
DATA_W, 8, byte width; fixed at 8 for the UART frame.
START_TIMEOUT, 16, max cycles from the tx_en pulse to tx_busy rising before a fault is declared; must be >= 2.

Ports:
sys_clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
req  in  NUM_REQ  per-requester request level; held with data until gnt.
req_data  in  NUM_REQ*8  packed bytes; requester i uses [8i+7:8i].
gnt  out  NUM_REQ  one-hot, 1-cycle pulse: byte latched, requester may change data.
done  out  NUM_REQ  one-hot, 1-cycle pulse: granted byte fully transmitted.
tx_data  out  8  byte to the transmitter, stable from LAUNCH until return to IDLE.
tx_en  out  1  1-cycle start pulse to the transmitter.
tx_busy  in  1  transmitter busy level: high from start bit through stop bit.
arb_busy  out  1  high in every state except IDLE.
err_timeout  out  1  sticky: tx_busy never rose after a launch.

Behaviour:
- Reset (async, active-low): state=IDLE; gnt=0, done=0, tx_en=0, tx_data=0, arb_busy=0, err_timeout=0; rr pointer=0.
- Priority: search starts at index ptr and wraps modulo NUM_REQ. The first asserted req wins. ptr<=winner+1 (wrapping) on grant.
- IDLE: if any req is high, at the next edge: gnt[w]=1 for 1 cycle, tx_data<=byte w, state<=LAUNCH. With no req, stay in IDLE.
- LAUNCH: tx_en=1 for exactly this cycle; state<=WAIT_START; timer cleared.
- WAIT_START: if tx_busy=1, state<=WAIT_DONE. Otherwise the timer increments. When timer==START_TIMEOUT-1: err_timeout<=1, state<=IDLE, no done pulse.
- WAIT_DONE: when tx_busy=0, done[w]=1 for 1 cycle and state<=IDLE.
- Latency: req high at edge n gives gnt at n+1, tx_en at n+2. After done, the next grant comes 1 cycle later at the earliest (IDLE visit mandatory).
- A requester holding req high after gnt is a new request. It waits its round-robin turn.
- req changes during a non-IDLE state are ignored. Latched tx_data is unaffected.
- tx_busy already high in IDLE (foreign traffic): no grant is issued until tx_busy=0.
- All outputs are registered; no combinational path from req to gnt.

Optional Feature:
UART_ARB_TAG_EN
- Defined: each grant transmits two frames. First is the tag byte {4'hA, winner[3:0]}, then the data byte. FSM adds TAG_LAUNCH/TAG_WAIT_START/TAG_WAIT_DONE ahead of LAUNCH. gnt pulses at the tag grant. done pulses only after the data frame. A timeout in either frame aborts the sequence.
- Undefined: single data frame only; no tag states or constants are synthesized.

Decomposition:
- Package uart_arb_pkg: FSM state enum (IDLE, LAUNCH, WAIT_START, WAIT_DONE, plus TAG_* states), TAG_HI=4'hA, timer width constant.
- Sub-module rr_priority_pick: combinational; inputs req and ptr; outputs a one-hot winner and a valid flag. It is reused by other shared-resource arbiters.

Test Plan:
- Single request: req[2]=1 with byte 8'h55 -> gnt[2] 1 cycle later; tx_en one cycle after that with tx_data=8'h55. Model raises tx_busy for 10 bit times -> done[2] 1 cycle after busy falls.
- Contention: req=4'b1111 with bytes 11/22/33/44 held -> grant order 0,1,2,3,0. Exactly one tx_en per grant; no overlap with tx_busy.
- Fairness: req[0] held continuously, req[3] asserted -> req[3] granted on the very next arbitration; req[0] is not granted twice in a row.
- Timeout: model never raises tx_busy -> err_timeout=1 exactly START_TIMEOUT cycles after tx_en; no done; next req still granted.
- Reset mid-frame: assert reset during WAIT_DONE -> all outputs 0 immediately; after release, ptr=0 and req[0] wins first.
- UART_ARB_TAG_EN: req[1]=8'hC3 -> tx_data sequence 8'hA1 then 8'hC3; two tx_en pulses; a single done[1].
